mul_32bits_iter: RTL

- Iterative 32x32 -> 64-bit shift-and-add multiplier for the EX stage of the pipelined CPU (MUL/MULU).
- Drives operands into one internal adder_32bits instance each cycle and consumes its sum and carry-out, so the carry-select adder is its direct downstream datapath.
- Presents a start/busy/done handshake to the pipeline control, which stalls EX while busy is high.

---
 rtl/mul_32bits_iter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/mul_32bits_iter.sv
// ============================================================================
// mul_32bits_iter
// ----------------------------------------------------------------------------
// Iterative 32x32 -> 64-bit shift-and-add multiplier for the EX stage
// (MUL / MULU). Operands are reduced to magnitudes on acceptance, 32
// shift-add iterations run through a single carry-select adder_32bits, and
// a final FIX cycle applies the sign. Latency is fixed at 33 cycles from
// accept to done, independent of the operand values.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request; only looked at in IDLE or DONE
//   is_signed  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   op_a       32-bit multiplicand (sampled with start)
//   op_b       32-bit multiplier   (sampled with start)
//   busy       high while in CALC or FIX (pipeline stalls EX)
//   done       one-cycle pulse; result is valid
//   result     64-bit product {hi,lo}; held until the next accepted start
// ============================================================================

// ----------------------------------------------------------------------------
// adder_32bits
// 32-bit carry-select adder. Every 4-bit block precomputes its sum for both
// carry-in values; the incoming block carry then selects one of them, so the
// critical path is one block add plus a chain of 2:1 muxes.
//
// Ports
//   a, b   32-bit addends
//   ci     carry in
//   sum    32-bit sum
//   co     carry out of bit 31
// ----------------------------------------------------------------------------
module adder_32bits (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ci,
   output logic [31:0] sum,
   output logic        co
);

   localparam int BLK  = 4;
   localparam int NBLK = 32 / BLK;

   // carry_chain[k] is the carry into block k
   logic [NBLK:0] carry_chain;

   assign carry_chain[0] = ci;

   genvar gi;
   generate
      for (gi = 0; gi < NBLK; gi++) begin : g_blk
         logic [BLK:0] sum_c0;
         logic [BLK:0] sum_c1;

         assign sum_c0 = {1'b0, a[gi*BLK +: BLK]} + {1'b0, b[gi*BLK +: BLK]};
         assign sum_c1 = {1'b0, a[gi*BLK +: BLK]} + {1'b0, b[gi*BLK +: BLK]}
                         + {{BLK{1'b0}}, 1'b1};

         assign sum[gi*BLK +: BLK]   = carry_chain[gi] ? sum_c1[BLK-1:0] : sum_c0[BLK-1:0];
         assign carry_chain[gi+1]    = carry_chain[gi] ? sum_c1[BLK]     : sum_c0[BLK];
      end
   endgenerate

   assign co = carry_chain[NBLK];

endmodule

// ----------------------------------------------------------------------------
// mul_32bits_iter (top)
// ----------------------------------------------------------------------------
module mul_32bits_iter #(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic        done,
   output logic [63:0] result
);

   localparam int            CW       = $clog2(ITER);
   localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state_reg;
   logic [31:0]   mcand_reg;
   logic [31:0]   acc_reg;
   logic [31:0]   mq_reg;
   logic          neg_reg;
   logic [CW-1:0] cnt_reg;
   logic [63:0]   result_reg;
   logic          busy_reg;
   logic          done_reg;

   // ------------------------------------------------------------------
   // Operand magnitudes. |0x80000000| stays 0x80000000, which read as an
   // unsigned 2^31 is exactly the magnitude the algorithm needs.
   // ------------------------------------------------------------------
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic        neg_next;

   assign mag_a    = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
   assign mag_b    = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
   assign neg_next = is_signed & (op_a[31] ^ op_b[31]);

   // ------------------------------------------------------------------
   // Shift-add datapath: add the multiplicand into the upper half when the
   // current multiplier LSB is set. The carry-out becomes the new MSB of
   // the accumulator through the right shift, so nothing is lost.
   // ------------------------------------------------------------------
   logic [31:0] addend;
   logic [31:0] add_sum;
   logic        add_co;

   assign addend = mq_reg[0] ? mcand_reg : 32'd0;

   adder_32bits u_adder (
      .a   (acc_reg),
      .b   (addend),
      .ci  (1'b0),
      .sum (add_sum),
      .co  (add_co)
   );

   // Final sign fix-up is local 64-bit logic, kept off the shared adder.
   logic [63:0] product_mag;
   logic [63:0] product_neg;

   assign product_mag = {acc_reg, mq_reg};
   assign product_neg = ~product_mag + 64'd1;

   // ------------------------------------------------------------------
   // Control FSM with registered busy/done/result.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         mcand_reg  <= '0;
         acc_reg    <= '0;
         mq_reg     <= '0;
         neg_reg    <= 1'b0;
         cnt_reg    <= '0;
         result_reg <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         case (state_reg)
            // IDLE and DONE both accept a new request; accepting in DONE
            // gives back-to-back operation with no idle gap.
            IDLE, DONE: begin
               done_reg <= 1'b0;
               if (start) begin
                  mcand_reg <= mag_a;
                  mq_reg    <= mag_b;
                  neg_reg   <= neg_next;
                  acc_reg   <= '0;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= CALC;
               end else begin
                  state_reg <= IDLE;
               end
            end

            CALC: begin
               {acc_reg, mq_reg} <= {add_co, add_sum, mq_reg[31:1]};
               cnt_reg           <= cnt_reg + CW'(1);
               if (cnt_reg == CNT_LAST) begin
                  state_reg <= FIX;
               end
            end

            FIX: begin
               result_reg <= neg_reg ? product_neg : product_mag;
               busy_reg   <= 1'b0;
               done_reg   <= 1'b1;
               state_reg  <= DONE;
            end

            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign busy   = busy_reg;
   assign done   = done_reg;
   assign result = result_reg;

endmodule
